regfile_mp: RTL and testbench

Parametrised multi-read-port, dual-write-port register file for the RISC-V core. It is the next-generation register file, with registered reads, an architectural x0 that always reads zero, and write-to-read bypass. A per-register pending scoreboard lets the issue stage detect load-use hazards. It sits between decode (read ports, scoreboard set) and writeback (ALU port 0, load port 1).

---
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port, dual-write-port register file with registered reads, hardwired x0,
// write-to-read bypass and a per-register pending scoreboard for load-use detection.

module regfile_mp_rdport #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] stored,
  input  logic                 busy_nxt,
  input  logic                 wr0_en,
  input  logic [ADDRWIDTH-1:0] wr0_addr,
  input  logic [DATAWIDTH-1:0] wr0_data,
  input  logic                 wr1_en,
  input  logic [ADDRWIDTH-1:0] wr1_addr,
  input  logic [DATAWIDTH-1:0] wr1_data,
  output logic [DATAWIDTH-1:0] data,
  output logic                 busy
);
  logic [DATAWIDTH-1:0] data_nxt;

  // wr0 outranks wr1 so the bypass agrees with what the array ends up holding
  always_comb begin
    data_nxt = stored;
    if (addr == '0)                           data_nxt = '0;
    else if (wr0_en && (wr0_addr == addr))    data_nxt = wr0_data;
    else if (wr1_en && (wr1_addr == addr))    data_nxt = wr1_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      data <= data_nxt;
      busy <= busy_nxt;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int NREAD     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREAD*ADDRWIDTH-1:0] rd_addr,
  output logic [NREAD*DATAWIDTH-1:0] rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDRWIDTH-1:0]       wr0_addr,
  input  logic [DATAWIDTH-1:0]       wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDRWIDTH-1:0]       wr1_addr,
  input  logic [DATAWIDTH-1:0]       wr1_data,
  input  logic                       sb_set_en,
  input  logic [ADDRWIDTH-1:0]       sb_set_addr,
  output logic [ADDRWIDTH:0]         pending_count
);
  localparam int NUM_REGS = 2**ADDRWIDTH;

  logic [NUM_REGS-1:0][DATAWIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                pending, pending_nxt, clr1, set;
  logic [ADDRWIDTH:0]                 cnt_nxt;

  always_comb begin
    clr1 = '0;
    set  = '0;
    if (wr1_en)    clr1[wr1_addr]    = 1'b1;
    if (sb_set_en) set[sb_set_addr]  = 1'b1;
    pending_nxt    = (pending & ~clr1) | set;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{ADDRWIDTH{1'b0}}, pending_nxt[i]};
  end

  // wr0 is applied last so it wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      if (wr1_en && (wr1_addr != '0)) regs[wr1_addr] <= wr1_data;
      if (wr0_en && (wr0_addr != '0)) regs[wr0_addr] <= wr0_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_count <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_mp_rdport #(.DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_rd (
      .clk      (clk),
      .rst      (rst),
      .addr     (rd_addr[k*ADDRWIDTH +: ADDRWIDTH]),
      .stored   (regs[rd_addr[k*ADDRWIDTH +: ADDRWIDTH]]),
      .busy_nxt (pending_nxt[rd_addr[k*ADDRWIDTH +: ADDRWIDTH]]),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .data     (rd_data[k*DATAWIDTH +: DATAWIDTH]),
      .busy     (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, reset sequences and a randomized run
// against an array-based reference model.

module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NREGS = 2**AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic            wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]   wr0_data, wr1_data;
  logic [AW:0]     pending_count;

  regfile_mp #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NREAD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state and per-step expectations
  logic [DW-1:0] m_regs [NREGS];
  bit   [NREGS-1:0] m_pend;
  logic [DW-1:0] e_d [NR];
  logic          e_b [NR];
  int            e_cnt;

  typedef struct {
    logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          se;  logic [AW-1:0] sa;
    logic [AW-1:0] r0;  logic [AW-1:0] r1;
    logic [DW-1:0] xd0; logic [DW-1:0] xd1; logic xb0; int xcnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  task automatic set_in(input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                        input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                        input logic se, input logic [AW-1:0] sa, input logic [NR*AW-1:0] ra);
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    sb_set_en = se; sb_set_addr = sa; rd_addr = ra;
  endtask

  // One clock: predict from the spec rules, take the edge, then commit the model.
  task automatic step();
    bit [NREGS-1:0] p;
    int a;
    p = m_pend;
    if (wr1_en) p[wr1_addr] = 1'b0;
    if (sb_set_en) p[sb_set_addr] = 1'b1;
    p[0] = 1'b0;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (a == 0) e_d[k] = '0;
      else if (wr0_en && int'(wr0_addr) == a) e_d[k] = wr0_data;
      else if (wr1_en && int'(wr1_addr) == a) e_d[k] = wr1_data;
      else e_d[k] = m_regs[a];
      e_b[k] = p[a];
    end
    e_cnt = $countones(p);
    @(posedge clk); #1;
    m_pend = p;
    if (wr1_en && wr1_addr != 0) m_regs[wr1_addr] = wr1_data;
    if (wr0_en && wr0_addr != 0) m_regs[wr0_addr] = wr0_data;
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s data%0d", tag, k), 64'(rd_data[k*DW +: DW]), 64'(e_d[k]));
      chk($sformatf("%s busy%0d", tag, k), 64'(rd_busy[k]), 64'(e_b[k]));
    end
    chk($sformatf("%s count", tag), 64'(pending_count), 64'(e_cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_data"}, 64'(rd_data == '0), 64'd1);
    chk({tag, " rd_busy"}, 64'(rd_busy), 64'd0);
    chk({tag, " count"}, 64'(pending_count), 64'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 32'h12345678, 32'h0, 1'b0, 0};
    tbl[1] = '{1'b0, 5'd5, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h12345678, 32'h0, 1'b0, 0};
    tbl[2] = '{1'b1, 5'd7, 32'hA,        1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA, 32'h12345678, 1'b0, 0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'hC, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA, 32'h12345678, 1'b0, 0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 32'h0, 32'hA, 1'b1, 1};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd0, 32'h55, 32'h0, 1'b1, 1};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h66, 1'b0, 5'd9, 5'd9, 5'd0, 32'h66, 32'h0, 1'b0, 0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h66, 32'h66, 1'b1, 1};
    tbl[8] = '{1'b1, 5'd9, 32'h77,       1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h77, 32'h0, 1'b1, 1};
    tbl[9] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, '0);
    model_reset();
    #2;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      set_in(tbl[i].w0e, tbl[i].w0a, tbl[i].w0d, tbl[i].w1e, tbl[i].w1a, tbl[i].w1d,
             tbl[i].se, tbl[i].sa, {10'd0, tbl[i].r1, tbl[i].r0});
      step();
      chk($sformatf("vec%0d d0", i), 64'(rd_data[0 +: DW]), 64'(tbl[i].xd0));
      chk($sformatf("vec%0d d1", i), 64'(rd_data[DW +: DW]), 64'(tbl[i].xd1));
      chk($sformatf("vec%0d b0", i), 64'(rd_busy[0]), 64'(tbl[i].xb0));
      chk($sformatf("vec%0d cnt", i), 64'(pending_count), 64'(tbl[i].xcnt));
    end

    for (int c = 0; c < 10000; c++) begin
      logic [NR*AW-1:0] ra;
      logic [AW-1:0] a0, a1, a2;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a2 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int k = 0; k < NR; k++)
        ra[k*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      @(negedge clk);
      set_in(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
             ($urandom_range(0, 2) == 0), a2, ra);
      step();
      chk_all($sformatf("rand%0d", c));
    end

    // mid-run reset while writes and a set are in flight
    @(negedge clk);
    set_in(1, 5'd5, 32'hCAFE0001, 1, 5'd6, 32'hCAFE0002, 1, 5'd5, {5'd6, 5'd5, 5'd6, 5'd5});
    rst = 1'b1;
    #1;
    chk_zero("async rst");
    @(posedge clk); #1;
    chk_zero("held rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 32'hDEADBEEF, 0, 0, {5'd6, 5'd5, 5'd0, 5'd0});
    step();
    chk("post rst r0", 64'(rd_data[0 +: DW]), 64'd0);
    chk("post rst r5", 64'(rd_data[2*DW +: DW]), 64'd0);
    chk("post rst r6", 64'(rd_data[3*DW +: DW]), 64'd0);
    chk("post rst cnt", 64'(pending_count), 64'd0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, '0);
    step();
    chk("x0 after write", 64'(rd_data[0 +: DW]), 64'd0);
    chk_all("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
